// File: rtl/logic_plotter.sv
// Logic analyser: captures CHANNELS synchronized inputs into a DEPTH-sample buffer
// on a trigger and draws each channel as a lane of green/red pixels on a VGA raster.

module VgaTiming #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       blank
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == 10'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Sync pulses are active-high so that 0 is the idle level after reset.
    assign x     = h_cnt;
    assign y     = v_cnt;
    assign hsync = (h_cnt >= 10'(H_ACTIVE + H_FP)) && (h_cnt < 10'(H_ACTIVE + H_FP + H_SYNC));
    assign vsync = (v_cnt >= 10'(V_ACTIVE + V_FP)) && (v_cnt < 10'(V_ACTIVE + V_FP + V_SYNC));
    assign blank = (h_cnt >= 10'(H_ACTIVE)) || (v_cnt >= 10'(V_ACTIVE));
endmodule

module logic_plotter #(
    parameter int CHANNELS       = 4,
    parameter int ADDR_WIDTH     = 9,
    parameter int PRESCALE_WIDTH = 15,
    parameter int H_ACTIVE       = 640,
    parameter int H_FP           = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BP           = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FP           = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BP           = 33
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      clear,
    input  logic                      continuous,
    input  logic [CHANNELS-1:0]       bits_in,
    input  logic [CHANNELS-1:0]       trig_mask,
    input  logic [CHANNELS-1:0]       trig_value,
    input  logic [PRESCALE_WIDTH-1:0] prescale_div,
    output logic                      r,
    output logic                      g,
    output logic                      b,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      armed,
    output logic                      capturing,
    output logic                      done,
    output logic [ADDR_WIDTH:0]       fill_count
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_F = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    state_t                    state, state_d;
    logic [ADDR_WIDTH:0]       fill_d;
    logic [ADDR_WIDTH:0]       fill_inc;
    logic [CHANNELS-1:0]       sync_meta, sync_in;
    logic [PRESCALE_WIDTH-1:0] pre_cnt;
    logic                      tick, trig_hit, cnt_zero;
    logic                      mem_we;
    logic [ADDR_WIDTH-1:0]     mem_waddr;
    logic [CHANNELS-1:0]       mem [DEPTH];
    logic [CHANNELS-1:0]       rd_data;

    logic [9:0] vga_x, vga_y;
    logic       vga_hs, vga_vs, vga_blank;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync_in   <= '0;
        end else begin
            sync_meta <= bits_in;
            sync_in   <= sync_meta;
        end
    end

    assign tick     = (pre_cnt == prescale_div);
    assign trig_hit = ((sync_in & trig_mask) == (trig_value & trig_mask));
    assign fill_inc = fill_count + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 pre_cnt <= '0;
        else if (cnt_zero || tick) pre_cnt <= '0;
        else                       pre_cnt <= pre_cnt + 1'b1;
    end

    always_comb begin
        state_d   = state;
        fill_d    = fill_count;
        mem_we    = 1'b0;
        mem_waddr = '0;
        cnt_zero  = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
            fill_d  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_d  = S_ARMED;
                        cnt_zero = 1'b1;
                    end
                end
                S_ARMED: begin
                    // The previous image stays in memory until this point.
                    if (tick && trig_hit) begin
                        mem_we  = 1'b1;
                        fill_d  = {{ADDR_WIDTH{1'b0}}, 1'b1};
                        state_d = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (tick) begin
                        mem_we    = 1'b1;
                        mem_waddr = fill_count[ADDR_WIDTH-1:0];
                        fill_d    = fill_inc;
                        if (fill_inc == DEPTH_F) state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_d  = S_ARMED;
                        cnt_zero = 1'b1;
                    end else if (continuous && vga_vs) begin
                        state_d = S_ARMED;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            fill_count <= '0;
        end else begin
            state      <= state_d;
            fill_count <= fill_d;
        end
    end

    assign armed     = (state == S_ARMED);
    assign capturing = (state == S_CAPTURE);
    assign done      = (state == S_DONE);

    // Read-before-write: a same-cycle write to the read address returns old data.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= sync_in;
        rd_data <= mem[vga_x[ADDR_WIDTH-1:0]];
    end

    VgaTiming #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_vga (
        .clk   (clk),
        .reset (reset),
        .x     (vga_x),
        .y     (vga_y),
        .hsync (vga_hs),
        .vsync (vga_vs),
        .blank (vga_blank)
    );

    // y[9] folds into the lane so rows past 511 count as an out-of-range lane.
    logic [3:0] lane_ext;
    logic       pix_void;
    assign lane_ext = vga_y[9:6];
    assign pix_void = vga_blank
                   || (lane_ext >= 4'(CHANNELS))
                   || ({1'b0, vga_x} >= 11'(DEPTH))
                   || (vga_y[5:0] >= 6'd56)
                   || ({1'b0, vga_x[ADDR_WIDTH-1:0]} >= fill_count);

    logic       void_q, hs_q, vs_q;
    logic [2:0] lane_q;
    logic [7:0] rd_pad;
    logic       pix_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            void_q <= 1'b1;
            lane_q <= '0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
        end else begin
            void_q <= pix_void;
            lane_q <= vga_y[8:6];
            hs_q   <= vga_hs;
            vs_q   <= vga_vs;
        end
    end

    assign rd_pad  = {{(8 - CHANNELS){1'b0}}, rd_data};
    assign pix_bit = rd_pad[lane_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r     <= 1'b0;
            g     <= 1'b0;
            b     <= 1'b0;
            hsync <= 1'b0;
            vsync <= 1'b0;
        end else begin
            r     <= ~void_q & ~pix_bit;
            g     <= ~void_q & pix_bit;
            b     <= 1'b0;
            hsync <= hs_q;
            vsync <= vs_q;
        end
    end
endmodule

// File: doc/logic_plotter.md
LOGIC_PLOTTER -- requirements
Module: logic_plotter

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, meaning number of sampled input bits, legal range 1..7.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, meaning log2 of samples per channel (DEPTH = 2^ADDR_WIDTH, max 9).
REQ-003 SHALL have parameter PRESCALE_WIDTH, default 15, meaning width of the sample-period divider.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: arm a capture.
REQ-007 SHALL have port clear, input, 1 bit: abort and blank the display.
REQ-008 SHALL have port continuous, input, 1 bit: auto-rearm mode.
REQ-009 SHALL have port bits_in, input, CHANNELS bits: asynchronous signals to capture.
REQ-010 SHALL have port trig_mask, input, CHANNELS bits: channels participating in the trigger.
REQ-011 SHALL have port trig_value, input, CHANNELS bits: required levels on the masked channels.
REQ-012 SHALL have port prescale_div, input, PRESCALE_WIDTH bits: sample period minus one.
REQ-013 SHALL have ports r, g, b, hsync, vsync, each output, 1 bit, registered VGA outputs.
REQ-014 SHALL have ports armed, capturing, done, each output, 1 bit: one-hot capture state (all 0 = IDLE).
REQ-015 SHALL have port fill_count, output, ADDR_WIDTH+1 bits: number of valid stored samples.

Function
REQ-016 SHALL pass bits_in through a 2-flop synchronizer; sampling and trigger use only the synchronized value (sync_in).
REQ-017 SHALL run the prescaler: counter increments each cycle; when counter == prescale_div, a one-cycle tick is asserted and counter returns to 0; sample period = prescale_div+1 cycles; prescale_div = 0 gives a tick every cycle.
REQ-018 SHALL zero the prescaler counter on any accepted start.
REQ-019 SHALL implement FSM IDLE, ARMED, CAPTURE, DONE.
REQ-020 SHALL make the IDLE/DONE -> ARMED transition on start.
REQ-021 SHALL ignore start in ARMED and CAPTURE.
REQ-022 SHALL make the ARMED -> CAPTURE transition on a tick where (sync_in & trig_mask) == (trig_value & trig_mask); trig_mask = 0 triggers on the first tick.
REQ-023 SHALL write the triggering tick's sample to address 0 and set fill_count to 1 on that same cycle.
REQ-024 SHALL, in CAPTURE, on each tick write sync_in to address fill_count and increment fill_count.
REQ-025 SHALL make the CAPTURE -> DONE transition on the tick that makes fill_count == DEPTH; fill_count never exceeds DEPTH.
REQ-026 SHALL, in DONE with continuous = 1, go to ARMED on the first cycle VgaTiming vsync is active; with continuous = 0, stay in DONE until start.
REQ-027 SHALL keep fill_count and memory contents on re-arm until the next trigger, so the previous capture stays visible.
REQ-028 SHALL make clear take the FSM to IDLE and fill_count to 0 from any state; clear has priority over start and over a tick in the same cycle.
REQ-029 SHALL instantiate VgaTiming (clk, x, y, hsync, vsync, blank) for display timing.
REQ-030 SHALL derive display coordinates from VgaTiming outputs: lane = y[8:6], sample index = x[ADDR_WIDTH-1:0].
REQ-031 SHALL treat a pixel as void if blank, lane >= CHANNELS, x >= DEPTH, y[5:0] >= 56 (lane gap), or sample index >= fill_count.
REQ-032 SHALL drive non-void pixels as green (r=0, g=1) when the stored bit of channel lane is 1 and red (r=1, g=0) when it is 0; void pixels SHALL output r = g = 0; b SHALL always be 0.
REQ-033 SHALL read sample memory synchronously (1 cycle); a write and read to the same address in one cycle returns old data.
REQ-034 SHALL register r, g, b, hsync, vsync exactly 2 cycles after the corresponding VgaTiming outputs, with hsync/vsync delayed identically to the colours.

Reset
REQ-035 SHALL, on reset, immediately set FSM = IDLE, fill_count = 0, prescaler = 0, synchronizer flops = 0, r = g = b = 0, hsync = vsync = 0 (inactive), and armed = capturing = done = 0.
REQ-036 SHALL NOT require memory contents to be reset; fill_count = 0 blanks them.
REQ-037 SHALL, on reset asserted mid-capture, abandon the capture with no further writes.

Verification
REQ-038 SHALL verify that with prescale_div=0, trig_mask=0, start pulse, CHANNELS=4, DEPTH=512: capturing rises 1 cycle after start; done after 512 ticks; fill_count = 512.
REQ-039 SHALL verify that with prescale_div=3: writes occur every 4th cycle; 10 ticks -> fill_count = 10, and pixels at x >= 10 are black.
REQ-040 SHALL verify that with trig_mask=4'b0010, trig_value=4'b0010, and bits_in[1] held 0 then raised: FSM stays ARMED until 2 sync cycles + next tick after the rise, and the address-0 sample has bit1 = 1.
REQ-041 SHALL verify that clear and start asserted together mid-capture -> IDLE, fill_count = 0, and the whole frame is black except hsync/vsync.
REQ-042 SHALL verify that with continuous=1 after done: armed asserts in the first vsync cycle, and the old image persists until the trigger.
REQ-043 SHALL verify that reset asserted mid-capture -> outputs at reset values before the next clock edge, and fill_count = 0.
